// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives imem_addr, captures fetched word into IF/ID.
// Latency: one cycle from imem_addr to id_*; a redirect costs exactly one bubble.
// Backpressure: stall freezes PC and IF/ID; a memory miss holds PC and injects a bubble.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   input  logic        flush,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [31:0] id_instruction,
   output logic [6:0]  id_opcode,
   output logic        fetch_misaligned,
   output logic [31:0] fetch_count
);

   // What the stage does on the coming edge, in priority order.
   typedef enum logic [2:0] {
      ACT_REDIRECT = 3'd0,
      ACT_FLUSH    = 3'd1,
      ACT_STALL    = 3'd2,
      ACT_MISS     = 3'd3,
      ACT_FETCH    = 3'd4
   } fetch_act_e;

   localparam logic [6:0] NOP_OPCODE = NOP_INSTR[6:0];

   fetch_act_e  act;

   logic [31:0] pc_q,              pc_d;
   logic        id_valid_q,        id_valid_d;
   logic [31:0] id_pc_q,           id_pc_d;
   logic [31:0] id_pc_plus4_q,     id_pc_plus4_d;
   logic [31:0] id_instruction_q,  id_instruction_d;
   logic [6:0]  id_opcode_q,       id_opcode_d;
   logic        fetch_misaligned_q, fetch_misaligned_d;
   logic [31:0] fetch_count_q,     fetch_count_d;

   logic [31:0] pc_plus4;

   // PC arithmetic wraps naturally at 2^32.
   assign pc_plus4  = pc_q + 32'd4;
   assign imem_addr = pc_q;

   // Resolve the competing control inputs into a single action.
   always_comb begin
      act = ACT_FETCH;
      if (redirect) begin
         act = ACT_REDIRECT;
      end else if (flush) begin
         act = ACT_FLUSH;
      end else if (stall) begin
         act = ACT_STALL;
      end else if (!imem_valid) begin
         act = ACT_MISS;
      end
   end

   // Next-state for PC, IF/ID register and status outputs.
   always_comb begin
      // Default: hold everything, misaligned pulse drops.
      pc_d               = pc_q;
      id_valid_d         = id_valid_q;
      id_pc_d            = id_pc_q;
      id_pc_plus4_d      = id_pc_plus4_q;
      id_instruction_d   = id_instruction_q;
      id_opcode_d        = id_opcode_q;
      fetch_misaligned_d = 1'b0;
      fetch_count_d      = fetch_count_q;

      case (act)
         ACT_REDIRECT: begin
            // Low two bits are dropped; the misalignment is only flagged.
            pc_d               = {redirect_target[31:2], 2'b00};
            fetch_misaligned_d = |redirect_target[1:0];
            id_valid_d         = 1'b0;
            id_instruction_d   = NOP_INSTR;
            id_opcode_d        = NOP_OPCODE;
         end
         ACT_FLUSH: begin
            // The squashed word still consumes its fetch slot if it arrived.
            if (imem_valid && !stall) begin
               pc_d = pc_plus4;
            end
            id_valid_d       = 1'b0;
            id_instruction_d = NOP_INSTR;
            id_opcode_d      = NOP_OPCODE;
         end
         ACT_STALL: begin
            // Defaults already hold PC, IF/ID and the counter.
         end
         ACT_MISS: begin
            id_valid_d       = 1'b0;
            id_instruction_d = NOP_INSTR;
            id_opcode_d      = NOP_OPCODE;
         end
         default: begin
            pc_d             = pc_plus4;
            id_valid_d       = 1'b1;
            id_pc_d          = pc_q;
            id_pc_plus4_d    = pc_plus4;
            id_instruction_d = imem_rdata;
            id_opcode_d      = imem_rdata[6:0];
            fetch_count_d    = fetch_count_q + 32'd1;
         end
      endcase
   end

   // State register; reset overrides every control input in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q               <= RESET_PC;
         id_valid_q         <= 1'b0;
         id_pc_q            <= 32'd0;
         id_pc_plus4_q      <= 32'd0;
         id_instruction_q   <= NOP_INSTR;
         id_opcode_q        <= NOP_OPCODE;
         fetch_misaligned_q <= 1'b0;
         fetch_count_q      <= 32'd0;
      end else begin
         pc_q               <= pc_d;
         id_valid_q         <= id_valid_d;
         id_pc_q            <= id_pc_d;
         id_pc_plus4_q      <= id_pc_plus4_d;
         id_instruction_q   <= id_instruction_d;
         id_opcode_q        <= id_opcode_d;
         fetch_misaligned_q <= fetch_misaligned_d;
         fetch_count_q      <= fetch_count_d;
      end
   end

   assign id_valid         = id_valid_q;
   assign id_pc            = id_pc_q;
   assign id_pc_plus4      = id_pc_plus4_q;
   assign id_instruction   = id_instruction_q;
   assign id_opcode        = id_opcode_q;
   assign fetch_misaligned = fetch_misaligned_q;
   assign fetch_count      = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, redirect, misalignment, miss, flush, wrap, reset.
// Inputs change after the falling edge; outputs are sampled on the falling edge.
// Instruction memory is modelled as a pure function of the fetch address.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instruction;
   logic [6:0]  id_opcode;
   logic        fetch_misaligned;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   if_stage dut (
      .clk              (clk),
      .rst              (rst),
      .imem_addr        (imem_addr),
      .imem_rdata       (imem_rdata),
      .imem_valid       (imem_valid),
      .stall            (stall),
      .redirect         (redirect),
      .redirect_target  (redirect_target),
      .flush            (flush),
      .id_valid         (id_valid),
      .id_pc            (id_pc),
      .id_pc_plus4      (id_pc_plus4),
      .id_instruction   (id_instruction),
      .id_opcode        (id_opcode),
      .fetch_misaligned (fetch_misaligned),
      .fetch_count      (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory word for an address: upper half is the address, opcode field is addr[8:2].
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], 9'h000, a[8:2]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Check the whole IF/ID register plus PC and counter after an edge.
   task automatic chk_id(input string tag, input logic [31:0] pc, input logic vld,
                         input logic [31:0] ipc, input logic [31:0] instr,
                         input logic [31:0] cnt);
      chk({tag, ".pc"},    imem_addr, pc);
      chk({tag, ".vld"},   {31'd0, id_valid}, {31'd0, vld});
      chk({tag, ".idpc"},  id_pc, ipc);
      chk({tag, ".instr"}, id_instruction, instr);
      chk({tag, ".op"},    {25'd0, id_opcode}, {25'd0, instr[6:0]});
      chk({tag, ".cnt"},   fetch_count, cnt);
   endtask

   initial begin
      rst = 1'b1; imem_valid = 1'b0; stall = 1'b0; redirect = 1'b0;
      redirect_target = 32'd0; flush = 1'b0;
      tick();
      chk_id("rst", 32'd0, 1'b0, 32'd0, NOP, 32'd0);
      chk("rst.p4",  id_pc_plus4, 32'd0);
      chk("rst.mis", {31'd0, fetch_misaligned}, 32'd0);

      // Two normal fetches: pc 0 and 4.
      rst = 1'b0; imem_valid = 1'b1;
      tick();
      chk_id("f0", 32'd4, 1'b1, 32'd0, mem_word(32'd0), 32'd1);
      chk("f0.p4", id_pc_plus4, 32'd4);
      tick();
      chk_id("f1", 32'd8, 1'b1, 32'd4, mem_word(32'd4), 32'd2);

      // Stall two cycles at pc=8.
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_id("stall", 32'd8, 1'b1, 32'd4, mem_word(32'd4), 32'd2);
      end
      stall = 1'b0;
      tick();
      chk_id("f2", 32'd12, 1'b1, 32'd8, mem_word(32'd8), 32'd3);
      tick();
      chk_id("f3", 32'd16, 1'b1, 32'd12, mem_word(32'd12), 32'd4);
      chk("f3.p4", id_pc_plus4, 32'd16);

      // Redirect wins over stall; id_pc keeps the last real value.
      redirect = 1'b1; redirect_target = 32'h100; stall = 1'b1;
      tick();
      chk_id("rd", 32'h100, 1'b0, 32'd12, NOP, 32'd4);
      chk("rd.mis", {31'd0, fetch_misaligned}, 32'd0);
      redirect = 1'b0; stall = 1'b0;
      tick();
      chk_id("rdt", 32'h104, 1'b1, 32'h100, mem_word(32'h100), 32'd5);
      chk("rdt.p4", id_pc_plus4, 32'h104);

      // Misaligned target: low bits dropped, one-cycle flag.
      redirect = 1'b1; redirect_target = 32'h102;
      tick();
      chk_id("mis", 32'h100, 1'b0, 32'h100, NOP, 32'd5);
      chk("mis.flag", {31'd0, fetch_misaligned}, 32'd1);
      redirect = 1'b0;
      tick();
      chk("mis.drop", {31'd0, fetch_misaligned}, 32'd0);
      chk_id("mist", 32'h104, 1'b1, 32'h100, mem_word(32'h100), 32'd6);

      // Three miss cycles: pc holds, bubbles, counter unchanged.
      imem_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_id("miss", 32'h104, 1'b0, 32'h100, NOP, 32'd6);
      end
      imem_valid = 1'b1;
      tick();
      chk_id("mrec", 32'h108, 1'b1, 32'h104, mem_word(32'h104), 32'd7);

      // Flush with a valid word: pc advances, word squashed, no count.
      flush = 1'b1;
      tick();
      chk_id("fl", 32'h10C, 1'b0, 32'h104, NOP, 32'd7);
      // Flush with stall: pc holds.
      stall = 1'b1;
      tick();
      chk_id("flst", 32'h10C, 1'b0, 32'h104, NOP, 32'd7);
      flush = 1'b0; stall = 1'b0;

      // Wrap at the top of the address space.
      redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
      tick();
      chk("wr.pc", imem_addr, 32'hFFFF_FFFC);
      redirect = 1'b0;
      tick();
      chk_id("wrap", 32'd0, 1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 32'd8);
      chk("wrap.p4", id_pc_plus4, 32'd0);

      // Reset together with redirect, stall and flush.
      rst = 1'b1; redirect = 1'b1; redirect_target = 32'h203; stall = 1'b1; flush = 1'b1;
      tick();
      chk_id("rst2", 32'd0, 1'b0, 32'd0, NOP, 32'd0);
      chk("rst2.p4",  id_pc_plus4, 32'd0);
      chk("rst2.mis", {31'd0, fetch_misaligned}, 32'd0);

      // Clean fetch straight out of reset.
      rst = 1'b0; redirect = 1'b0; stall = 1'b0; flush = 1'b0;
      tick();
      chk_id("post", 32'd4, 1'b1, 32'd0, mem_word(32'd0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
